riscv_hazard_mc: RTL and testbench

Parametrised hazard, forwarding and multi-cycle stall controller for the 5-stage pipelined RISC-V core. It replaces the single-cycle hazard unit. It adds an execute-stage occupancy FSM, so floating-point ops that complete through the FPU's `FPValid` handshake hold the pipeline until their result is ready. A watchdog counter bounds that wait. It sits beside the pipeline registers: it reads register addresses and control bits from stages D/E/M/W and drives stall, flush, forward and FPU-start controls.

---
 rtl/riscv_hazard_mc_if.sv | 44 ++++
 rtl/riscv_hazard_mc.sv | 109 ++++++++++
 tb/tb_riscv_hazard_mc.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/riscv_hazard_mc_if.sv
// Pipeline-side signal bundle for the hazard/forwarding/multi-cycle stall controller.
// The pipeline (master) drives register addresses and control bits. The controller (slave) drives stall, flush and forwarding controls.
interface riscv_hazard_mc_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] Rs1D;
  logic [REG_AW-1:0] Rs2D;
  logic [REG_AW-1:0] Rs1E;
  logic [REG_AW-1:0] Rs2E;
  logic [REG_AW-1:0] RdE;
  logic [REG_AW-1:0] RdM;
  logic [REG_AW-1:0] RdW;
  logic              RegWriteM;
  logic              RegWriteW;
  logic              LoadE;
  logic              PCSrcE;
  logic              FPE;
  logic              FPValid;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              StallF;
  logic              StallD;
  logic              StallE;
  logic              FlushD;
  logic              FlushE;
  logic              FlushM;
  logic              FPStart;
  logic              FPBusy;
  logic              FPTimeout;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, LoadE, PCSrcE, FPE, FPValid,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE,
    input  FlushD, FlushE, FlushM, FPStart, FPBusy, FPTimeout
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, LoadE, PCSrcE, FPE, FPValid,
    output ForwardAE, ForwardBE, StallF, StallD, StallE,
    output FlushD, FlushE, FlushM, FPStart, FPBusy, FPTimeout
  );
endinterface

// File: rtl/riscv_hazard_mc.sv
// Hazard, forwarding and multi-cycle stall controller for the 5-stage RISC-V pipeline.
// An execute-stage FSM holds F/D/E while an FPU op waits for FPValid, and a watchdog bounds that wait.
module riscv_hazard_mc #(
  parameter int REG_AW  = 5,
  parameter int MAX_LAT = 16,
  parameter bit FP_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  riscv_hazard_mc_if.slave      hz
);

  localparam int CNT_W = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LAT - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic             fp_hold;
  logic             fp_start;
  logic             lw_stall;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  // Forwarding from M takes priority over W, and x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic [REG_AW-1:0] rd_m,
                                         input logic              we_m,
                                         input logic [REG_AW-1:0] rd_w,
                                         input logic              we_w);
    if (rs != '0 && we_m && rs == rd_m)      return 2'b10;
    else if (rs != '0 && we_w && rs == rd_w) return 2'b01;
    else                                     return 2'b00;
  endfunction

  assign fwd_a = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
  assign fwd_b = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);

  assign lw_stall = hz.LoadE && (hz.RdE != '0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  // NOTE: every variable gets a default before the case so that no path
  // leaves it unassigned, otherwise synthesis infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    fp_hold   = 1'b0;
    fp_start  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // FPValid is ignored here because the FPU cannot answer in the start cycle.
        if (FP_EN && hz.FPE) begin
          fp_start = 1'b1;
          fp_hold  = 1'b1;
          state_d  = ST_BUSY;
          cnt_d    = '0;
        end
      end
      ST_BUSY: begin
        if (hz.FPValid) begin
          state_d = ST_IDLE;
        end else if (cnt_q < CNT_LAST) begin
          fp_hold = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          // The watchdog releases the pipeline. ex_mem takes whatever the FPU bus holds.
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // While reset is high, all stall, flush, start and forwarding controls are forced to 0.
  always_comb begin
    hz.ForwardAE = reset ? 2'b00 : fwd_a;
    hz.ForwardBE = reset ? 2'b00 : fwd_b;
    hz.StallF    = !reset && (lw_stall || fp_hold);
    hz.StallD    = !reset && (lw_stall || fp_hold);
    hz.StallE    = !reset && fp_hold;
    hz.FlushM    = !reset && fp_hold;
    hz.FlushD    = !reset && hz.PCSrcE;
    hz.FlushE    = !reset && (lw_stall || hz.PCSrcE) && !fp_hold;
    hz.FPStart   = !reset && fp_start;
    hz.FPBusy    = FP_EN && (state_q == ST_BUSY);
    hz.FPTimeout = FP_EN && timeout_q;
  end

endmodule

// File: tb/tb_riscv_hazard_mc.sv
// Directed self-checking bench for riscv_hazard_mc.
// Control outputs are packed as {StallF,StallD,StallE,FlushD,FlushE,FlushM,FPStart,FPBusy,FPTimeout}.
module tb_riscv_hazard_mc;

  localparam int REG_AW  = 5;
  localparam int MAX_LAT = 16;

  localparam logic [8:0] C_IDLE  = 9'b000000000;
  localparam logic [8:0] C_START = 9'b111001100;
  localparam logic [8:0] C_HOLD  = 9'b111001010;
  localparam logic [8:0] C_REL   = 9'b000000010;
  localparam logic [8:0] C_TMO   = 9'b000000001;
  localparam logic [8:0] C_LW    = 9'b110010000;
  localparam logic [8:0] C_BR    = 9'b000110000;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  riscv_hazard_mc_if #(.REG_AW(REG_AW)) hz_if ();

  riscv_hazard_mc #(
    .REG_AW (REG_AW),
    .MAX_LAT(MAX_LAT),
    .FP_EN  (1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ctl();
    return {hz_if.StallF, hz_if.StallD, hz_if.StallE, hz_if.FlushD, hz_if.FlushE,
            hz_if.FlushM, hz_if.FPStart, hz_if.FPBusy, hz_if.FPTimeout};
  endfunction

  // Compare control outputs mid-cycle, then move to just after the next rising edge.
  task automatic cycle(input string tag, input logic [8:0] exp);
    @(negedge clk);
    check(tag, 32'(ctl()), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic fwd(input string tag, input logic [1:0] exp_a, input logic [1:0] exp_b);
    @(negedge clk);
    check({tag, "_A"}, 32'(hz_if.ForwardAE), 32'(exp_a));
    check({tag, "_B"}, 32'(hz_if.ForwardBE), 32'(exp_b));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset           = 1'b1;
    hz_if.Rs1D      = '0;
    hz_if.Rs2D      = '0;
    hz_if.Rs1E      = 5'd5;
    hz_if.Rs2E      = '0;
    hz_if.RdE       = '0;
    hz_if.RdM       = 5'd5;
    hz_if.RdW       = '0;
    hz_if.RegWriteM = 1'b1;
    hz_if.RegWriteW = 1'b0;
    hz_if.LoadE     = 1'b0;
    hz_if.PCSrcE    = 1'b1;
    hz_if.FPE       = 1'b1;
    hz_if.FPValid   = 1'b0;

    // During reset, forwarding, flush and start are all suppressed.
    fwd("rst_fwd", 2'b00, 2'b00);
    cycle("rst_ctl", C_IDLE);
    hz_if.PCSrcE = 1'b0;
    hz_if.FPE    = 1'b0;
    reset        = 1'b0;

    // Forwarding priority and x0 exclusion
    hz_if.RdW = 5'd5; hz_if.RegWriteW = 1'b1; hz_if.Rs2E = 5'd5;
    fwd("fwd_m", 2'b10, 2'b10);
    hz_if.RegWriteM = 1'b0;
    fwd("fwd_w", 2'b01, 2'b01);
    hz_if.Rs1E = 5'd0;
    fwd("fwd_x0", 2'b00, 2'b01);
    hz_if.Rs1E = 5'd5; hz_if.RegWriteW = 1'b0;
    fwd("fwd_none", 2'b00, 2'b00);
    hz_if.RegWriteM = 1'b1; hz_if.RegWriteW = 1'b1; hz_if.RdM = 5'd6; hz_if.Rs2E = 5'd6;
    fwd("fwd_mix", 2'b01, 2'b10);
    hz_if.RegWriteM = 1'b0; hz_if.RegWriteW = 1'b0;

    // Load-use stall lasts exactly one cycle once the load leaves E.
    hz_if.LoadE = 1'b1; hz_if.RdE = 5'd3; hz_if.Rs2D = 5'd3;
    cycle("lw_stall", C_LW);
    hz_if.LoadE = 1'b0;
    cycle("lw_done", C_IDLE);
    hz_if.LoadE = 1'b1; hz_if.RdE = 5'd0; hz_if.Rs1D = 5'd0;
    cycle("lw_x0", C_IDLE);
    hz_if.LoadE = 1'b0; hz_if.Rs2D = 5'd0;

    hz_if.PCSrcE = 1'b1;
    cycle("branch", C_BR);
    hz_if.PCSrcE = 1'b0;

    // FP op with latency 4. The op stays in E while held, so FPE stays high.
    hz_if.FPE = 1'b1;
    cycle("fp4_c0", C_START);
    for (int i = 1; i <= 3; i++) cycle($sformatf("fp4_c%0d", i), C_HOLD);
    hz_if.FPValid = 1'b1;
    cycle("fp4_c4", C_REL);
    hz_if.FPValid = 1'b0; hz_if.FPE = 1'b0;
    cycle("fp4_c5", C_IDLE);

    // Back-to-back ops with latency 1
    hz_if.FPE = 1'b1;
    cycle("b2b_c0", C_START);
    hz_if.FPValid = 1'b1;
    cycle("b2b_c1", C_REL);
    hz_if.FPValid = 1'b0;
    cycle("b2b_c2", C_START);
    hz_if.FPValid = 1'b1;
    cycle("b2b_c3", C_REL);
    hz_if.FPValid = 1'b0; hz_if.FPE = 1'b0;
    cycle("b2b_c4", C_IDLE);

    // Reset during BUSY cycle 2. A late FPValid must not change anything.
    hz_if.FPE = 1'b1;
    cycle("rb_c0", C_START);
    cycle("rb_c1", C_HOLD);
    reset = 1'b1;
    cycle("rb_c2", C_REL);
    reset = 1'b0; hz_if.FPE = 1'b0;
    cycle("rb_c3", C_IDLE);
    hz_if.FPValid = 1'b1;
    cycle("rb_c4", C_IDLE);
    hz_if.FPValid = 1'b0;

    // Watchdog: the FPU never answers.
    hz_if.FPE = 1'b1;
    cycle("wd_c0", C_START);
    for (int i = 1; i < MAX_LAT; i++) cycle($sformatf("wd_c%0d", i), C_HOLD);
    cycle("wd_rel", C_REL);
    hz_if.FPE = 1'b0;
    for (int i = 0; i < 3; i++) cycle($sformatf("wd_sticky%0d", i), C_TMO);
    reset = 1'b1;
    cycle("wd_rst", C_TMO);
    reset = 1'b0;
    cycle("wd_cleared", C_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
